// File: rtl/codificador_display_mux.sv
// Latches a DIGITS-nibble value, encodes it in one of four modes and scans it onto 7-segment digits.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module codificador_display_mux #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [4*DIGITS-1:0]   Input,
  input  logic [1:0]            Mode,
  input  logic                  Ready,
  output logic                  Busy,
  output logic [4*DIGITS-1:0]   Output,
  output logic                  Valid,
  output logic [6:0]            Display,
  output logic [DIGITS-1:0]     Anode
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    UPDATE
  } state_t;

  state_t         state;
  logic [W-1:0]   data_q;
  logic [1:0]     mode_q;
  logic [W-1:0]   result;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  idx;
  logic [3:0]     nib;
  logic           blank;

  function automatic logic [W-1:0] encode(
    input logic [W-1:0] x,
    input logic [1:0]   m
  );
    logic [W-1:0] r;
    r = x;
    unique case (m)
      2'b00: r = x;
      2'b01: r = x ^ (x >> 1);
      2'b10: begin
        // nibbles wrap independently, no carry
        for (int i = 0; i < DIGITS; i++)
          r[4*i +: 4] = x[4*i +: 4] + 4'd3;
      end
      default: r = ~x + W'(1);
    endcase
    return r;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state  <= IDLE;
      data_q <= '0;
      mode_q <= 2'b00;
      result <= '0;
      Output <= '0;
      Valid  <= 1'b0;
      Busy   <= 1'b0;
    end else begin
      Valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Ready) begin
            data_q <= Input;
            mode_q <= Mode;
            Busy   <= 1'b1;
            state  <= ENCODE;
          end
        end
        ENCODE: begin
          result <= encode(data_q, mode_q);
          state  <= UPDATE;
        end
        UPDATE: begin
          Output <= result;
          Valid  <= 1'b1;
          Busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign nib = Output[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  assign blank = (idx != '0) && ((Output >> {idx, 2'b00}) == '0);
`else
  assign blank = 1'b0;
`endif

  // scan runs freely, independent of the encoder
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cnt     <= '0;
      idx     <= '0;
      Anode   <= '0;
      Display <= 7'b0000000;
    end else begin
      Anode   <= DIGITS'(1) << idx;
      Display <= blank ? 7'b0000000 : seg(nib);
      if (cnt == CW'(SCAN_DIV - 1)) begin
        cnt <= '0;
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_codificador_display_mux.sv
// Directed bench with an output scoreboard and a per-cycle scan/segment model.
// Define LEADING_ZERO_BLANK_EN to check the blanking variant.
module tb_codificador_display_mux;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] Input;
  logic [1:0]  Mode;
  logic        Ready;
  logic        Busy;
  logic [15:0] Output;
  logic        Valid;
  logic [6:0]  Display;
  logic [3:0]  Anode;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcount = 0;
  logic [15:0] cur_out = '0;
  logic [15:0] q[$];
  logic [6:0]  seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  codificador_display_mux #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .Clock(Clock), .Reset(Reset), .Input(Input), .Mode(Mode),
    .Ready(Ready), .Busy(Busy), .Output(Output), .Valid(Valid),
    .Display(Display), .Anode(Anode));

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int i);
    logic [15:0] hi;
    hi = v >> (4 * i);
`ifdef LEADING_ZERO_BLANK_EN
    if (i != 0 && hi == 16'h0) return 7'b0000000;
`endif
    return seg_tab[hi[3:0]];
  endfunction

  task automatic step();
    logic [15:0] prev;
    logic [15:0] e;
    int i;
    prev = cur_out;
    @(posedge Clock);
    #1;
    if (!Reset) begin
      cyc = 0;
      cur_out = '0;
      q.delete();
      check("rst_output", Output, 0);
      check("rst_valid", Valid, 0);
      check("rst_busy", Busy, 0);
      check("rst_anode", Anode, 0);
      check("rst_display", Display, 0);
    end else begin
      cyc++;
      i = ((cyc - 1) / 4) % 4;
      check("anode", Anode, 32'(4'b0001 << i));
      check("display", Display, exp_seg(prev, i));
      if (Valid) begin
        vcount++;
        checks++;
        assert (q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_valid observed=%h expected=none", Output);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          check("output", Output, e);
          cur_out = e;
        end
      end
    end
  endtask

  task automatic drain(input int bound);
    for (int n = 0; n < bound && q.size() != 0; n++) step();
    check("drain_timeout", q.size(), 0);
  endtask

  task automatic encode_one(input logic [15:0] x, input logic [1:0] m,
                            input logic [15:0] exp);
    Input = x; Mode = m; Ready = 1'b1;
    q.push_back(exp);
    step();
    Ready = 1'b0; Input = ~x; Mode = ~m;
    check("busy_t", Busy, 1);
    step();
    check("busy_t1", Busy, 1);
    check("valid_t1", Valid, 0);
    step();
    check("busy_t2", Busy, 0);
    check("valid_t2", Valid, 1);
    check("sb_empty", q.size(), 0);
    step();
    check("valid_t3", Valid, 0);
  endtask

  initial begin
    int v0;
    Reset = 1'b0; Input = '0; Mode = 2'b00; Ready = 1'b0;
    step(); step();
    Reset = 1'b1;
    step();
    check("first_anode", Anode, 4'b0001);
    check("first_display", Display, 7'b1111110);

    encode_one(16'h1234, 2'b00, 16'h1234);
    encode_one(16'h000F, 2'b01, 16'h0008);
    encode_one(16'h0D9F, 2'b10, 16'h30C2);
    encode_one(16'h0001, 2'b11, 16'hFFFF);
    encode_one(16'h0000, 2'b11, 16'h0000);
    encode_one(16'h1234, 2'b00, 16'h1234);

    // full scan rotation and wrap checked by the per-cycle model
    repeat (20) step();

    // Ready held: only cycles 0 and 3 are captured
    v0 = vcount;
    Mode = 2'b00; Ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      Input = 16'hA000 + 16'(i);
      if (i == 0 || i == 3) q.push_back(16'hA000 + 16'(i));
      step();
    end
    Ready = 1'b0;
    drain(8);
    repeat (3) step();
    check("held_ready_valids", vcount - v0, 2);

    // reset mid-scan for 3 cycles
    repeat (2) step();
    Reset = 1'b0;
    repeat (3) step();
    Reset = 1'b1;
    step();
    check("rel_anode", Anode, 4'b0001);
    check("rel_display", Display, 7'b1111110);

    // reset during ENCODE aborts with no Valid
    v0 = vcount;
    Input = 16'h5A5A; Mode = 2'b00; Ready = 1'b1;
    q.push_back(16'h5A5A);
    step();
    Ready = 1'b0;
    check("abort_busy", Busy, 1);
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    repeat (6) step();
    check("abort_no_valid", vcount - v0, 0);
    check("abort_output", Output, 0);
    check("abort_busy_after", Busy, 0);

    encode_one(16'h0050, 2'b00, 16'h0050);
    repeat (18) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
